// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer: FSM states, address defaults,
// the fetched-entry record and the fetch-address legality check.
package fetch_pkg;

  localparam int                ADDR_W_DEF    = 32;
  localparam logic [31:0]       RESET_PC_DEF  = 32'd0;
  localparam int                MEM_BYTES_DEF = 400;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]           inst;
    logic [ADDR_W_DEF-1:0] pc;
  } fetch_entry_t;

  // A fetch address is illegal if it is not word aligned or lies past the last word.
  function automatic logic addr_fault(input logic [ADDR_W_DEF-1:0] addr,
                                      input logic [ADDR_W_DEF-1:0] last_addr);
    return (addr[1:0] != 2'b00) || (addr > last_addr);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bundle: imem req/ack port, EX redirect, IF/ID hand-off and fault.
// master = fetch sequencer side, slave = memory/pipeline environment side.
interface fetch_sequencer_if #(parameter int ADDR_W = 32);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              stall;
  logic              inst_valid;
  logic [31:0]       inst_out;
  logic [ADDR_W-1:0] inst_pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              fault;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect_valid, redirect_pc, stall,
    output inst_valid, inst_out, inst_pc, pc_plus4, fault
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect_valid, redirect_pc, stall,
    input  inst_valid, inst_out, inst_pc, pc_plus4, fault
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched word that arrives while IF/ID is full.
// Flush wins over load, load wins over drain; occupancy visible next cycle.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_drain,
  input  logic         i_flush,
  input  fetch_entry_t i_entry,
  output logic         o_full,
  output fetch_entry_t o_entry
);

  logic         r_full;
  fetch_entry_t r_entry;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full  <= 1'b0;
      r_entry <= '0;
    end else begin
      if (i_flush) begin
        r_full <= 1'b0;
      end else if (i_load) begin
        r_full <= 1'b1;
      end else if (i_drain) begin
        r_full <= 1'b0;
      end
      if (i_load && !i_flush) begin
        r_entry <= i_entry;
      end
    end
  end

  assign o_full  = r_full;
  assign o_entry = r_entry;

endmodule

// File: rtl/fetch_sequencer.sv
// MIPS fetch stage: owns the PC, issues word fetches, feeds IF/ID; same-cycle ack gives
// inst_valid one cycle after the request, stall holds the outputs and parks one word in the skid.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter int                MEM_BYTES = MEM_BYTES_DEF
)
(
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 4);
  localparam logic [ADDR_W-1:0] WORD      = ADDR_W'(4);

  fetch_state_e      r_state;
  fetch_state_e      w_next_state;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_in_flight;
  logic              r_drop;
  logic              r_inst_valid;
  logic [31:0]       r_inst_out;
  logic [ADDR_W-1:0] r_inst_pc;
  logic [ADDR_W-1:0] r_pc_plus4;

  logic              w_run;
  logic              w_consume;
  logic              w_slot_free;
  logic              w_start_ok;
  logic              w_pc_bad;
  logic              w_redir_bad;
  logic [ADDR_W-1:0] w_req_addr;
  logic              w_req;
  logic              w_ack;
  logic              w_take;
  logic              w_skid_full;
  logic              w_skid_load;
  logic              w_skid_drain;
  logic              w_skid_flush;
  fetch_entry_t      w_ack_entry;
  fetch_entry_t      w_skid_entry;

  assign w_run       = (r_state == RUN);
  assign w_consume   = r_inst_valid && !bus.stall;
  assign w_slot_free = !r_inst_valid || w_consume;
  // A new fetch may start as long as the skid can absorb its data; a held request blocks it.
  assign w_start_ok  = w_run && !r_in_flight && !w_skid_full && !bus.redirect_valid;
  assign w_pc_bad    = addr_fault(r_pc, LAST_ADDR);
  assign w_redir_bad = addr_fault(bus.redirect_pc, LAST_ADDR);
  assign w_req_addr  = r_in_flight ? r_req_addr : r_pc;
  assign w_req       = w_run && (r_in_flight || (w_start_ok && !w_pc_bad));
  assign w_ack       = w_req && bus.imem_ack;
  // Data from a redirected-away request, or acked alongside a redirect, is thrown away.
  assign w_take      = w_ack && !r_drop && !bus.redirect_valid;

  assign w_ack_entry  = '{inst: bus.imem_rdata, pc: w_req_addr};
  assign w_skid_load  = w_take && !w_slot_free;
  assign w_skid_drain = w_run && !bus.redirect_valid && w_consume && w_skid_full;
  assign w_skid_flush = w_run && bus.redirect_valid;

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_flush (w_skid_flush),
    .i_entry (w_ack_entry),
    .o_full  (w_skid_full),
    .o_entry (w_skid_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RUN: begin
        if (bus.redirect_valid) begin
          if (w_redir_bad) begin
            w_next_state = FAULT;
          end
        end else if (w_start_ok && w_pc_bad) begin
          w_next_state = FAULT;
        end
      end
      FAULT:   w_next_state = FAULT;
      default: w_next_state = RUN;
    endcase
  end

  always_comb begin
    bus.imem_req   = 1'b0;
    bus.imem_addr  = w_req_addr;
    bus.inst_valid = 1'b0;
    bus.fault      = 1'b0;
    bus.inst_out   = r_inst_out;
    bus.inst_pc    = r_inst_pc;
    bus.pc_plus4   = r_pc_plus4;
    case (r_state)
      RUN: begin
        bus.imem_req   = w_req;
        bus.inst_valid = r_inst_valid;
      end
      FAULT:   bus.fault = 1'b1;
      default: bus.fault = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_in_flight  <= 1'b0;
      r_drop       <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst_out   <= '0;
      r_inst_pc    <= '0;
      r_pc_plus4   <= WORD;
    end else if (w_run) begin
      if (w_next_state == FAULT) begin
        r_inst_valid <= 1'b0;
        r_in_flight  <= 1'b0;
        r_drop       <= 1'b0;
      end else if (bus.redirect_valid) begin
        r_pc         <= bus.redirect_pc;
        r_inst_valid <= 1'b0;
        // An unacked request must still complete on the bus; remember to discard it.
        r_in_flight  <= r_in_flight && !bus.imem_ack;
        r_drop       <= r_in_flight && !bus.imem_ack;
      end else begin
        if (w_ack) begin
          r_in_flight <= 1'b0;
          r_drop      <= 1'b0;
          if (!r_drop) begin
            r_pc <= r_pc + WORD;
          end
        end else if (w_req && !r_in_flight) begin
          r_in_flight <= 1'b1;
          r_req_addr  <= r_pc;
        end

        if (w_take && w_slot_free) begin
          r_inst_valid <= 1'b1;
          r_inst_out   <= bus.imem_rdata;
          r_inst_pc    <= w_req_addr;
          r_pc_plus4   <= w_req_addr + WORD;
        end else if (w_consume) begin
          if (w_skid_full) begin
            r_inst_valid <= 1'b1;
            r_inst_out   <= w_skid_entry.inst;
            r_inst_pc    <= w_skid_entry.pc;
            r_pc_plus4   <= w_skid_entry.pc + WORD;
          end else begin
            r_inst_valid <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a latency-programmable instruction memory.
module tb_fetch_sequencer;

  logic clk;
  logic rst;
  int   lat;
  int   wait_cnt;
  int   n_checks;
  int   n_fails;

  fetch_sequencer_if #(.ADDR_W(32)) bus();

  fetch_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  always_comb begin
    bus.imem_ack   = bus.imem_req && (wait_cnt >= lat);
    bus.imem_rdata = mem_word(bus.imem_addr);
  end

  always @(posedge clk) begin
    if (rst || !bus.imem_req || bus.imem_ack) wait_cnt <= 0;
    else                                      wait_cnt <= wait_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.stall          = 1'b0;
    lat = 0;
    tick();
    #1;
    check_eq("rst_valid",    bus.inst_valid, 32'd0);
    check_eq("rst_inst_out", bus.inst_out,   32'd0);
    check_eq("rst_inst_pc",  bus.inst_pc,    32'd0);
    check_eq("rst_pc_plus4", bus.pc_plus4,   32'd4);
    check_eq("rst_fault",    bus.fault,      32'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst      = 1'b1;
    lat      = 0;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    do_reset();

    // Back-to-back same-cycle acks: one instruction per cycle.
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("seq_req",  bus.imem_req,  32'd1);
      check_eq("seq_addr", bus.imem_addr, 32'(4 * i));
      if (i == 0) begin
        check_eq("seq_first_valid", bus.inst_valid, 32'd0);
      end else begin
        check_eq("seq_valid",    bus.inst_valid, 32'd1);
        check_eq("seq_inst_pc",  bus.inst_pc,    32'(4 * (i - 1)));
        check_eq("seq_inst_out", bus.inst_out,   mem_word(32'(4 * (i - 1))));
        check_eq("seq_pc_plus4", bus.pc_plus4,   32'(4 * i));
      end
      tick();
    end

    // Three stall cycles: first one fills the skid, then requests stop.
    bus.stall = 1'b1;
    #1;
    check_eq("stall_skid_req",  bus.imem_req,  32'd1);
    check_eq("stall_skid_addr", bus.imem_addr, 32'd20);
    check_eq("stall_hold_pc",   bus.inst_pc,   32'd16);
    tick();
    for (int k = 0; k < 2; k++) begin
      #1;
      check_eq("stall_no_req",  bus.imem_req,   32'd0);
      check_eq("stall_valid",   bus.inst_valid, 32'd1);
      check_eq("stall_hold_pc", bus.inst_pc,    32'd16);
      tick();
    end
    bus.stall = 1'b0;
    #1;
    check_eq("drain_no_req",  bus.imem_req, 32'd0);
    check_eq("drain_last_pc", bus.inst_pc,  32'd16);
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("post_stall_valid",    bus.inst_valid, 32'd1);
      check_eq("post_stall_inst_pc",  bus.inst_pc,    32'(20 + 4 * k));
      check_eq("post_stall_inst_out", bus.inst_out,   mem_word(32'(20 + 4 * k)));
      tick();
    end

    // Two-cycle memory latency: request held three cycles, one valid per request.
    lat = 2;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        #1;
        check_eq("lat_req",  bus.imem_req,  32'd1);
        check_eq("lat_addr", bus.imem_addr, 32'(36 + 4 * r));
        if (k == 0) begin
          check_eq("lat_valid",   bus.inst_valid, 32'd1);
          check_eq("lat_inst_pc", bus.inst_pc,    32'(32 + 4 * r));
        end else begin
          check_eq("lat_gap_valid", bus.inst_valid, 32'd0);
        end
        tick();
      end
    end
    #1;
    check_eq("lat_last_pc", bus.inst_pc, 32'd40);

    // Redirect to 0x40 while the 0x10 fetch is still waiting for its ack.
    do_reset();
    for (int k = 0; k < 4; k++) tick();
    lat = 2;
    #1;
    check_eq("redir_pre_addr", bus.imem_addr, 32'h10);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    #1;
    check_eq("redir_hold_req",  bus.imem_req,   32'd1);
    check_eq("redir_hold_addr", bus.imem_addr,  32'h10);
    check_eq("redir_valid",     bus.inst_valid, 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    check_eq("drop_req",   bus.imem_req,   32'd1);
    check_eq("drop_addr",  bus.imem_addr,  32'h10);
    check_eq("drop_valid", bus.inst_valid, 32'd0);
    tick();
    lat = 0;
    #1;
    check_eq("redir_new_addr", bus.imem_addr,  32'h40);
    check_eq("redir_no_stale", bus.inst_valid, 32'd0);
    tick();
    #1;
    check_eq("redir_first_valid", bus.inst_valid, 32'd1);
    check_eq("redir_first_pc",    bus.inst_pc,    32'h40);
    check_eq("redir_first_inst",  bus.inst_out,   mem_word(32'h40));

    // Redirect coinciding with an ack while IF/ID is stalled.
    bus.stall = 1'b1;
    lat = 1;
    #1;
    check_eq("rs_req_addr", bus.imem_addr, 32'h44);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    #1;
    check_eq("rs_ack_addr", bus.imem_addr, 32'h44);
    tick();
    bus.redirect_valid = 1'b0;
    bus.stall = 1'b0;
    lat = 0;
    #1;
    check_eq("rs_valid_clr", bus.inst_valid, 32'd0);
    check_eq("rs_next_req",  bus.imem_req,   32'd1);
    check_eq("rs_next_addr", bus.imem_addr,  32'h80);
    tick();
    #1;
    check_eq("rs_tgt_pc", bus.inst_pc, 32'h80);
    tick();
    #1;
    check_eq("rs_tgt_pc_next", bus.inst_pc, 32'h84);
    tick();

    // Misaligned redirect target traps.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h42;
    tick();
    bus.redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("mis_fault", bus.fault,      32'd1);
      check_eq("mis_req",   bus.imem_req,   32'd0);
      check_eq("mis_valid", bus.inst_valid, 32'd0);
      tick();
    end
    do_reset();
    #1;
    check_eq("mis_rst_fault", bus.fault,     32'd0);
    check_eq("mis_rst_addr",  bus.imem_addr, 32'd0);
    tick();

    // Sequential fetch walks off the end of the 400-byte memory.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd392;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    check_eq("end_req_392", bus.imem_addr, 32'd392);
    tick();
    #1;
    check_eq("end_pc_392",  bus.inst_pc,   32'd392);
    check_eq("end_req_396", bus.imem_addr, 32'd396);
    tick();
    #1;
    check_eq("end_pc_396",   bus.inst_pc,  32'd396);
    check_eq("end_plus4",    bus.pc_plus4, 32'd400);
    check_eq("end_no_req",   bus.imem_req, 32'd0);
    check_eq("end_pre_flt",  bus.fault,    32'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("oor_fault", bus.fault,      32'd1);
      check_eq("oor_req",   bus.imem_req,   32'd0);
      check_eq("oor_valid", bus.inst_valid, 32'd0);
      tick();
    end
    do_reset();
    #1;
    check_eq("oor_rst_fault", bus.fault,      32'd0);
    check_eq("oor_rst_valid", bus.inst_valid, 32'd0);
    check_eq("oor_rst_addr",  bus.imem_addr,  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
